// File: rtl/hci_package.sv
// Shared types and constants for the HCI copy-chain protection blocks.
package hci_package;

    // Deepest supported skew between the main and the copy chain.
    localparam int HCI_COPY_MAX_DELAY = 4;

    // Field widths the packed copy structs are built with.
    localparam int HCI_COPY_DW  = 32;
    localparam int HCI_COPY_AW  = 32;
    localparam int HCI_COPY_BW  = 8;
    localparam int HCI_COPY_UW  = 1;
    localparam int HCI_COPY_IW  = 1;
    localparam int HCI_COPY_EW  = 1;
    localparam int HCI_COPY_EHW = 1;

    // Request-direction fields that are replayed onto the copy chain.
    typedef struct packed {
        logic                                 req;
        logic [HCI_COPY_AW-1:0]               add;
        logic                                 wen;
        logic [HCI_COPY_DW-1:0]               data;
        logic [HCI_COPY_DW/HCI_COPY_BW-1:0]   be;
        logic [HCI_COPY_UW-1:0]               user;
        logic [HCI_COPY_IW-1:0]               id;
        logic [HCI_COPY_EW-1:0]               ecc;
        logic [HCI_COPY_EHW-1:0]              ereq;
        logic                                 r_ready;
        logic [HCI_COPY_EHW-1:0]              r_eready;
    } hci_copy_req_t;

    // Response-direction fields of the main chain, delayed for comparison.
    typedef struct packed {
        logic                                 req;
        logic                                 gnt;
        logic                                 r_valid;
        logic [HCI_COPY_DW-1:0]               r_data;
        logic [HCI_COPY_UW-1:0]               r_user;
        logic [HCI_COPY_IW-1:0]               r_id;
        logic                                 r_opc;
        logic [HCI_COPY_EHW-1:0]              egnt;
        logic [HCI_COPY_EHW-1:0]              r_evalid;
        logic [HCI_COPY_EW-1:0]               r_ecc;
    } hci_copy_rsp_t;

    // Only the handshake bits of the request pipeline need a reset value;
    // payload is ignored while req is low.
    localparam hci_copy_req_t HCI_COPY_REQ_RST_MASK = '{
        req:      1'b1,
        add:      '0,
        wen:      1'b0,
        data:     '0,
        be:       '0,
        user:     '0,
        id:       '0,
        ecc:      '0,
        ereq:     '1,
        r_ready:  1'b1,
        r_eready: '1
    };

endpackage

// File: rtl/hci_core_intf.sv
// HCI core-side memory interface with initiator, target and monitor views.
interface hci_core_intf #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BW  = 8,
    parameter int UW  = 1,
    parameter int IW  = 1,
    parameter int EW  = 1,
    parameter int EHW = 1
) ();

    logic                 req;
    logic                 gnt;
    logic [AW-1:0]        add;
    logic                 wen;
    logic [DW-1:0]        data;
    logic [DW/BW-1:0]     be;
    logic [UW-1:0]        user;
    logic [IW-1:0]        id;
    logic [EW-1:0]        ecc;
    logic [EHW-1:0]       ereq;
    logic [EHW-1:0]       egnt;
    logic                 r_valid;
    logic                 r_ready;
    logic [DW-1:0]        r_data;
    logic [UW-1:0]        r_user;
    logic [IW-1:0]        r_id;
    logic                 r_opc;
    logic [EW-1:0]        r_ecc;
    logic [EHW-1:0]       r_evalid;
    logic [EHW-1:0]       r_eready;

    modport initiator (
        output req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
        input  gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, r_evalid
    );

    modport target (
        input  req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
        output gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, r_evalid
    );

    modport monitor (
        input req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
        input gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, r_evalid
    );

endinterface

// File: rtl/hci_copy_delay_line.sv
// Fixed-depth shift register of a packed type; on reset only the bits
// selected by RST_MASK are forced to RST_VAL, the rest keep their value.
module hci_copy_delay_line #(
    parameter int  DEPTH    = 1,
    parameter type T        = logic,
    parameter T    RST_VAL  = '0,
    parameter T    RST_MASK = '1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  T     d_i,
    output T     q_o
);

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        T q;
        T prev;

        if (g == 0) begin : g_head
            assign prev = d_i;
        end else begin : g_tail
            assign prev = g_stage[g-1].q;
        end

        // Advance one stage per cycle, flushing the masked bits on reset.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q <= T'((q & ~RST_MASK) | (RST_VAL & RST_MASK));
            end else begin
                q <= prev;
            end
        end
    end

    assign q_o = g_stage[DEPTH-1].q;

endmodule

// File: rtl/hci_copy_source_delayed.sv
// Head of a duplicated HCI chain: replays the main request stream onto the
// copy chain DELAY cycles late and checks the copy responses against the
// equally delayed main responses.
module hci_copy_source_delayed
    import hci_package::*;
#(
    parameter int DELAY = 1,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int BW    = 8,
    parameter int UW    = 1,
    parameter int IW    = 1,
    parameter int EW    = 1,
    parameter int EHW   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hci_core_intf.monitor    tcdm_main,
    hci_core_intf.initiator  tcdm_copy,
    input  logic             clear_i,
    output logic             fault_o,
    output logic             fault_sticky_o,
    output logic [CNT_W-1:0] fault_count_o
);

    localparam int              WARM_W  = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DELAY < 1 || DELAY > HCI_COPY_MAX_DELAY) begin : g_bad_delay
        $error("hci_copy_source_delayed: DELAY must be within 1..4");
    end

    if (DW != HCI_COPY_DW || AW != HCI_COPY_AW || BW != HCI_COPY_BW ||
        UW != HCI_COPY_UW || IW != HCI_COPY_IW || EW != HCI_COPY_EW ||
        EHW != HCI_COPY_EHW) begin : g_bad_width
        $error("hci_copy_source_delayed: widths must match hci_package copy structs");
    end

    hci_copy_req_t    req_in;
    hci_copy_req_t    req_dly;
    hci_copy_rsp_t    rsp_in;
    hci_copy_rsp_t    rsp_dly;
    logic [WARM_W-1:0] warm_q;
    logic             mismatch;
    logic             unused_rsp_req;

    assign req_in = '{
        req:      tcdm_main.req,
        add:      tcdm_main.add,
        wen:      tcdm_main.wen,
        data:     tcdm_main.data,
        be:       tcdm_main.be,
        user:     tcdm_main.user,
        id:       tcdm_main.id,
        ecc:      tcdm_main.ecc,
        ereq:     tcdm_main.ereq,
        r_ready:  tcdm_main.r_ready,
        r_eready: tcdm_main.r_eready
    };

    assign rsp_in = '{
        req:      tcdm_main.req,
        gnt:      tcdm_main.gnt,
        r_valid:  tcdm_main.r_valid,
        r_data:   tcdm_main.r_data,
        r_user:   tcdm_main.r_user,
        r_id:     tcdm_main.r_id,
        r_opc:    tcdm_main.r_opc,
        egnt:     tcdm_main.egnt,
        r_evalid: tcdm_main.r_evalid,
        r_ecc:    tcdm_main.r_ecc
    };

    hci_copy_delay_line #(
        .DEPTH    (DELAY),
        .T        (hci_copy_req_t),
        .RST_VAL  ('0),
        .RST_MASK (HCI_COPY_REQ_RST_MASK)
    ) u_req_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (req_in),
        .q_o   (req_dly)
    );

    hci_copy_delay_line #(
        .DEPTH    (DELAY),
        .T        (hci_copy_rsp_t),
        .RST_VAL  ('0),
        .RST_MASK ('1)
    ) u_rsp_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rsp_in),
        .q_o   (rsp_dly)
    );

    assign tcdm_copy.req      = req_dly.req;
    assign tcdm_copy.add      = req_dly.add;
    assign tcdm_copy.wen      = req_dly.wen;
    assign tcdm_copy.data     = req_dly.data;
    assign tcdm_copy.be       = req_dly.be;
    assign tcdm_copy.user     = req_dly.user;
    assign tcdm_copy.id       = req_dly.id;
    assign tcdm_copy.ecc      = req_dly.ecc;
    assign tcdm_copy.ereq     = req_dly.ereq;
    assign tcdm_copy.r_ready  = req_dly.r_ready;
    assign tcdm_copy.r_eready = req_dly.r_eready;

    // The delayed req travels with the responses for debug visibility only.
    assign unused_rsp_req = rsp_dly.req;

    // Hold off comparison until the pipelines contain real traffic again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            warm_q <= WARM_W'(DELAY);
        end else if (warm_q != '0) begin
            warm_q <= warm_q - 1'b1;
        end
    end

    // Handshakes always compared; response payload only when main r_valid.
    always_comb begin
        mismatch = 1'b0;
        if (warm_q == '0) begin
            if ((rsp_dly.gnt      != tcdm_copy.gnt)     ||
                (rsp_dly.egnt     != tcdm_copy.egnt)    ||
                (rsp_dly.r_valid  != tcdm_copy.r_valid) ||
                (rsp_dly.r_evalid != tcdm_copy.r_evalid)) begin
                mismatch = 1'b1;
            end
            if (rsp_dly.r_valid &&
                ((rsp_dly.r_data != tcdm_copy.r_data) ||
                 (rsp_dly.r_user != tcdm_copy.r_user) ||
                 (rsp_dly.r_id   != tcdm_copy.r_id)   ||
                 (rsp_dly.r_opc  != tcdm_copy.r_opc)  ||
                 (rsp_dly.r_ecc  != tcdm_copy.r_ecc))) begin
                mismatch = 1'b1;
            end
        end
    end

    // Fault reporting; a new mismatch takes priority over clear_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_o        <= 1'b0;
            fault_sticky_o <= 1'b0;
            fault_count_o  <= '0;
        end else begin
            fault_o <= mismatch;
            if (mismatch) begin
                fault_sticky_o <= 1'b1;
                if (clear_i) begin
                    fault_count_o <= CNT_W'(1);
                end else if (fault_count_o != CNT_MAX) begin
                    fault_count_o <= fault_count_o + 1'b1;
                end
            end else if (clear_i) begin
                fault_sticky_o <= 1'b0;
                fault_count_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hci_copy_source_delayed.sv
// Directed bench: one DELAY=1 and one DELAY=2 instance watch the same main
// chain, each with its own copy chain driven by the bench.
module tb_hci_copy_source_delayed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       fault1, sticky1, fault2, sticky2;
    logic [7:0] count1, count2;
    int         vectors_applied = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1), .IW(1), .EW(1), .EHW(1)) main_if ();
    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1), .IW(1), .EW(1), .EHW(1)) copy1_if ();
    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1), .IW(1), .EW(1), .EHW(1)) copy2_if ();

    hci_copy_source_delayed #(.DELAY(1), .CNT_W(8)) u_dut1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .tcdm_main      (main_if),
        .tcdm_copy      (copy1_if),
        .clear_i        (clear),
        .fault_o        (fault1),
        .fault_sticky_o (sticky1),
        .fault_count_o  (count1)
    );

    hci_copy_source_delayed #(.DELAY(2), .CNT_W(8)) u_dut2 (
        .clk_i          (clk),
        .rst_i          (rst),
        .tcdm_main      (main_if),
        .tcdm_copy      (copy2_if),
        .clear_i        (clear),
        .fault_o        (fault2),
        .fault_sticky_o (sticky2),
        .fault_count_o  (count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic wen, input logic [31:0] add,
                                 input logic [31:0] data, input logic gnt,
                                 input logic r_valid, input logic [31:0] r_data);
        main_if.req      = req;
        main_if.wen      = wen;
        main_if.add      = add;
        main_if.data     = data;
        main_if.be       = 4'hF;
        main_if.user     = '0;
        main_if.id       = '0;
        main_if.ecc      = '0;
        main_if.ereq     = '0;
        main_if.r_ready  = 1'b1;
        main_if.r_eready = '0;
        main_if.gnt      = gnt;
        main_if.egnt     = '0;
        main_if.r_valid  = r_valid;
        main_if.r_data   = r_data;
        main_if.r_user   = '0;
        main_if.r_id     = '0;
        main_if.r_opc    = 1'b0;
        main_if.r_ecc    = '0;
        main_if.r_evalid = '0;
    endtask

    task automatic setCopy1(input logic gnt, input logic r_valid, input logic [31:0] r_data);
        copy1_if.gnt      = gnt;
        copy1_if.egnt     = '0;
        copy1_if.r_valid  = r_valid;
        copy1_if.r_data   = r_data;
        copy1_if.r_user   = '0;
        copy1_if.r_id     = '0;
        copy1_if.r_opc    = 1'b0;
        copy1_if.r_ecc    = '0;
        copy1_if.r_evalid = '0;
    endtask

    task automatic setCopy2(input logic gnt, input logic r_valid, input logic [31:0] r_data);
        copy2_if.gnt      = gnt;
        copy2_if.egnt     = '0;
        copy2_if.r_valid  = r_valid;
        copy2_if.r_data   = r_data;
        copy2_if.r_user   = '0;
        copy2_if.r_id     = '0;
        copy2_if.r_opc    = 1'b0;
        copy2_if.r_ecc    = '0;
        copy2_if.r_evalid = '0;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        setCopy1(1'b0, 1'b0, 32'h0);
        setCopy2(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of both instances.
        checkOutput("rst_fault1", fault1, 0);
        checkOutput("rst_sticky1", sticky1, 0);
        checkOutput("rst_count1", count1, 0);
        checkOutput("rst_copy1_req", copy1_if.req, 0);
        checkOutput("rst_fault2", fault2, 0);
        checkOutput("rst_count2", count2, 0);
        checkOutput("rst_copy2_req", copy2_if.req, 0);
        tick();
        tick();
        tick();

        // DELAY=1 write replay with matching copy grant.
        applyStimulus(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("d1_copy_req", copy1_if.req, 1);
        checkOutput("d1_copy_add", copy1_if.add, 32'h100);
        checkOutput("d1_copy_data", copy1_if.data, 32'hDEADBEEF);
        checkOutput("d1_copy_wen", copy1_if.wen, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        setCopy1(1'b1, 1'b0, 32'h0);
        tick();
        setCopy1(1'b0, 1'b0, 32'h0);
        checkOutput("d1_copy_req_drop", copy1_if.req, 0);
        checkOutput("d1_fault_match", fault1, 0);
        tick();
        checkOutput("d1_fault_idle", fault1, 0);
        checkOutput("d1_sticky", sticky1, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();

        // DELAY=2 read data mismatch.
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        setCopy2(1'b0, 1'b1, 32'h1235);
        tick();
        setCopy2(1'b0, 1'b0, 32'h0);
        checkOutput("d2_rdata_fault", fault2, 1);
        checkOutput("d2_rdata_sticky", sticky2, 1);
        checkOutput("d2_rdata_count", count2, 1);
        tick();
        checkOutput("d2_fault_pulse_end", fault2, 0);
        checkOutput("d2_count_hold", count2, 1);

        // Clear, then payload difference while r_valid low must not fault.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_count", count2, 0);
        checkOutput("clear_sticky", sticky2, 0);
        setCopy2(1'b0, 1'b0, 32'hFFFF);
        tick();
        tick();
        tick();
        checkOutput("rdata_masked_fault", fault2, 0);
        checkOutput("rdata_masked_count", count2, 0);

        // Spurious copy grant.
        setCopy2(1'b1, 1'b0, 32'h0);
        tick();
        setCopy2(1'b0, 1'b0, 32'h0);
        checkOutput("gnt_fault", fault2, 1);
        tick();
        checkOutput("gnt_fault_end", fault2, 0);
        checkOutput("gnt_count", count2, 1);

        // Persistent mismatch saturates the counter.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        setCopy2(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 255; i++) tick();
        checkOutput("sat_count_255", count2, 255);
        for (int i = 0; i < 45; i++) tick();
        checkOutput("sat_count_hold", count2, 255);
        checkOutput("sat_sticky", sticky2, 1);
        checkOutput("sat_fault", fault2, 1);
        setCopy2(1'b0, 1'b0, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("sat_clear_count", count2, 0);
        checkOutput("sat_clear_sticky", sticky2, 0);
        checkOutput("sat_clear_fault", fault2, 0);

        // Reset with a request in flight, then garbage during warm-up.
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("flush_copy_req", copy2_if.req, 0);
        setCopy2(1'b1, 1'b1, 32'hBAD);
        tick();
        checkOutput("warm_fault_1", fault2, 0);
        tick();
        checkOutput("warm_fault_2", fault2, 0);
        checkOutput("warm_sticky", sticky2, 0);
        tick();
        setCopy2(1'b0, 1'b0, 32'h0);
        checkOutput("post_warm_fault", fault2, 1);
        tick();
        checkOutput("post_warm_count", count2, 1);

        // Clear and mismatch in the same cycle: set/increment wins.
        clear = 1'b1;
        setCopy2(1'b1, 1'b0, 32'h0);
        tick();
        clear = 1'b0;
        setCopy2(1'b0, 1'b0, 32'h0);
        checkOutput("clr_vs_fault_sticky", sticky2, 1);
        checkOutput("clr_vs_fault_count", count2, 1);
        tick();
        checkOutput("clr_vs_fault_hold", count2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
